// File: rtl/ntt_pkg.sv
// Shared INTT datapath types: coefficient width, modulus, and the
// stage register layout used by the add/sub recombiner.
package ntt_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int Q          = 3329;
    localparam int TAG_WIDTH  = 8;

    typedef logic [DATA_WIDTH-1:0] coef_t;

    typedef struct packed {
        coef_t [1:0]          data;
        logic                 halve;
        logic [TAG_WIDTH-1:0] tag;
    } recover_pair_t;

endpackage

// File: rtl/mod_half.sv
// Conditional modular halving: y = x/2 mod Q when halve=1 (x in [0,Q), Q odd), else y = x.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mod_half #(
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic [W-1:0] x,
    input  logic         halve,
    output logic [W-1:0] y
);

    localparam logic [W:0] QW = (W+1)'(Q);

    logic [W:0] sum;

    // Odd x: x+Q is even, and its half is congruent to x/2 mod Q.
    assign sum = {1'b0, x} + QW;

    always_comb begin
        y = x;
        if (halve) begin
            y = x[0] ? sum[W:1] : {1'b0, x[W-1:1]};
        end
    end

endmodule

// File: rtl/add_sub_recover.sv
// INTT butterfly recombiner: out0 = (a+b)[/2] mod Q, out1 = (a-b)[/2] mod Q, tag carried along.
// Latency: 2 cycles from input transfer to out_valid; 1 pair/cycle throughput.
// Backpressure: bubble-collapsing valid/ready, in_ready combinational from out_ready, holds 2 pairs.
module add_sub_recover #(
    parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
    parameter int Q          = ntt_pkg::Q,
    parameter int TAG_WIDTH  = ntt_pkg::TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0][DATA_WIDTH-1:0] in_data,
    input  logic                       in_halve,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0][DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic                       range_err
);

    import ntt_pkg::*;

    localparam logic [DATA_WIDTH:0] QW = (DATA_WIDTH+1)'(Q);

    logic                       v1;
    logic                       v2;
    recover_pair_t              st1;
    recover_pair_t              nxt1;
    logic [1:0][DATA_WIDTH-1:0] d2;
    logic [TAG_WIDTH-1:0]       t2;
    logic [1:0][DATA_WIDTH-1:0] half_y;

    logic                       load1;
    logic                       load2;
    logic                       in_fire;
    logic                       bad_operand;

    logic [DATA_WIDTH:0]        a_ext;
    logic [DATA_WIDTH:0]        b_ext;
    logic [DATA_WIDTH:0]        s;
    logic [DATA_WIDTH:0]        d;
    logic [DATA_WIDTH:0]        s1;
    logic [DATA_WIDTH:0]        d1;

    assign load2    = !v2 || out_ready;
    assign load1    = !v1 || load2;
    assign in_ready = load1;
    assign in_fire  = in_valid && in_ready;

    assign a_ext = {1'b0, in_data[0]};
    assign b_ext = {1'b0, in_data[1]};
    assign s     = a_ext + b_ext;
    assign d     = a_ext - b_ext;

    // Top bit of d is the sign of a-b for in-range operands.
    always_comb begin
        s1 = (s >= QW) ? (s - QW) : s;
        d1 = d[DATA_WIDTH] ? (d + QW) : d;
        nxt1         = '0;
        nxt1.data[0] = s1[DATA_WIDTH-1:0];
        nxt1.data[1] = d1[DATA_WIDTH-1:0];
        nxt1.halve   = in_halve;
        nxt1.tag     = in_tag;
    end

    assign bad_operand = (a_ext >= QW) || (b_ext >= QW);

    for (genvar i = 0; i < 2; i++) begin : g_half
        mod_half #(
            .W (DATA_WIDTH),
            .Q (Q)
        ) u_mod_half (
            .x     (st1.data[i]),
            .halve (st1.halve),
            .y     (half_y[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            st1       <= '0;
            d2        <= '0;
            t2        <= '0;
            range_err <= 1'b0;
        end else begin
            if (load1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    st1 <= nxt1;
                end
            end
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= half_y;
                    t2 <= st1.tag;
                end
            end
            if (in_fire && bad_operand) begin
                range_err <= 1'b1;
            end
        end
    end

    assign out_valid = v2;
    assign out_data  = d2;
    assign out_tag   = t2;

endmodule

// File: tb/tb_add_sub_recover.sv
// Randomized and directed bench for add_sub_recover against a modular-arithmetic reference model.
module tb_add_sub_recover;

    localparam int DW   = 12;
    localparam int TW   = 8;
    localparam int QM   = 3329;
    localparam int HALF = (QM + 1) / 2;

    typedef struct {
        int o0;
        int o1;
        int tag;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [1:0][DW-1:0]  in_data;
    logic                in_halve;
    logic [TW-1:0]       in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [1:0][DW-1:0]  out_data;
    logic [TW-1:0]       out_tag;
    logic                range_err;

    int tests  = 0;
    int errors = 0;
    int popped = 0;

    exp_t               sb[$];
    bit                 held = 1'b0;
    logic [1:0][DW-1:0] prev_data;
    logic [TW-1:0]      prev_tag;

    always #5 clk = ~clk;

    add_sub_recover dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_halve  (in_halve),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .range_err (range_err)
    );

    // Halving mod Q is multiplication by the inverse of 2, (Q+1)/2.
    function automatic void model(input int a, input int b, input bit h, output int o0, output int o1);
        o0 = (a + b) % QM;
        o1 = (a - b + QM) % QM;
        if (h) begin
            o0 = (o0 * HALF) % QM;
            o1 = (o1 * HALF) % QM;
        end
    endfunction

    // Called at posedge+1: drives one cycle, checks outputs at +2, returns at next posedge+1.
    task automatic drive_cycle(input bit iv, input int a, input int b, input bit h,
                               input int tag, input bit ordy, output bit acc);
        exp_t e;
        int   o0;
        int   o1;
        in_valid   = iv;
        in_data[0] = a[DW-1:0];
        in_data[1] = b[DW-1:0];
        in_halve   = h;
        in_tag     = tag[TW-1:0];
        out_ready  = ordy;
        #1;
        tests++;
        if (in_ready !== ((sb.size() < 2) || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (occupancy %0d)", in_ready,
                     ((sb.size() < 2) || ordy), sb.size());
        end
        if (sb.size() == 0) begin
            tests++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_out_valid: got %b expected 0", out_valid);
            end
        end
        if (held) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
                errors++;
                $display("FAIL stall_stable: got v=%b %0d,%0d tag %0d expected v=1 %0d,%0d tag %0d",
                         out_valid, out_data[0], out_data[1], out_tag,
                         prev_data[0], prev_data[1], prev_tag);
            end
        end
        if (out_valid === 1'b1 && ordy) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got pair %0d,%0d tag %0d expected none",
                         out_data[0], out_data[1], out_tag);
            end else begin
                e = sb.pop_front();
                popped++;
                if (out_data[0] !== e.o0[DW-1:0] || out_data[1] !== e.o1[DW-1:0] ||
                    out_tag !== e.tag[TW-1:0]) begin
                    errors++;
                    $display("FAIL out_pair: got %0d,%0d tag %0d expected %0d,%0d tag %0d",
                             out_data[0], out_data[1], out_tag, e.o0, e.o1, e.tag);
                end
            end
        end
        acc = iv && (in_ready === 1'b1);
        if (acc) begin
            model(a, b, h, o0, o1);
            e.o0 = o0;
            e.o1 = o1;
            e.tag = tag & 8'hff;
            sb.push_back(e);
        end
        held      = (out_valid === 1'b1) && !ordy;
        prev_data = out_data;
        prev_tag  = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_halve  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || range_err !== 1'b0 ||
            out_data !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b err=%b data=%0d,%0d tag=%0d expected v=0 rdy=1 err=0 data=0,0 tag=0",
                     out_valid, in_ready, range_err, out_data[0], out_data[1], out_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int vec[6][5] = '{
            '{5,    3,    1, 4,    1},
            '{3,    5,    1, 4,    3328},
            '{3328, 3328, 1, 3328, 0},
            '{1,    0,    1, 1665, 1665},
            '{3000, 1000, 0, 671,  2000},
            '{0,    1,    0, 1,    3328}
        };
        bit acc;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, vec[i][0], vec[i][1], vec[i][2] != 0, i, 1'b1, acc);
            drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
            tests++;
            if (out_valid !== 1'b1 || out_data[0] !== vec[i][3][DW-1:0] ||
                out_data[1] !== vec[i][4][DW-1:0]) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b %0d,%0d expected v=1 %0d,%0d at 2 cycles",
                         i, out_valid, out_data[0], out_data[1], vec[i][3], vec[i][4]);
            end
            drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        end
    endtask

    task automatic test_back_to_back();
        int  idx = 0;
        int  cyc = 0;
        int  base;
        bit  acc;
        bit  ordy;
        base = popped;
        while ((idx < 10 || sb.size() > 0) && cyc < 300) begin
            if (cyc == 7) begin
                tests++;
                if (sb.size() != 2 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_full: got occupancy %0d in_ready %b expected 2 and 0",
                             sb.size(), in_ready);
                end
            end
            ordy = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
            drive_cycle(idx < 10, $urandom_range(0, QM - 1), $urandom_range(0, QM - 1),
                        1'($urandom_range(0, 1)), idx, ordy, acc);
            if (acc) idx++;
            cyc++;
        end
        tests++;
        if (popped - base != 10 || sb.size() != 0) begin
            errors++;
            $display("FAIL backpressure_count: got %0d pairs out expected 10", popped - base);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        bit acc;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, QM - 1),
                        $urandom_range(0, QM - 1), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 255), 1'($urandom_range(0, 3) != 0), acc);
        end
        while (sb.size() > 0 && cyc < 20) begin
            drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
            cyc++;
        end
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pairs left expected 0", sb.size());
        end
    endtask

    task automatic test_range_err();
        in_valid   = 1'b1;
        in_data[0] = 12'd3329;
        in_data[1] = 12'd0;
        in_halve   = 1'b1;
        in_tag     = 8'd77;
        out_ready  = 1'b1;
        #1;
        tests++;
        if (range_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL range_err_before: got err=%b rdy=%b expected err=0 rdy=1", range_err, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (range_err !== 1'b1) begin
                errors++;
                $display("FAIL range_err_sticky_%0d: got %b expected 1", i, range_err);
            end
            @(posedge clk);
            #1;
        end
        held = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bit acc;
        drive_cycle(1'b1, 10, 20, 1'b0, 1, 1'b0, acc);
        drive_cycle(1'b1, 30, 40, 1'b1, 2, 1'b0, acc);
        tests++;
        if (sb.size() != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_fill: got occupancy %0d in_ready %b expected 2 and 0", sb.size(), in_ready);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b err=%b rdy=%b expected v=0 err=0 rdy=1",
                     out_valid, range_err, in_ready);
        end
        sb.delete();
        held  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_range_err();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/add_sub_recover.md
# add_sub_recover

Inverse-side modular butterfly recombiner for the INTT datapath: it accepts a pair (a, b) in [0, Q) and produces out0 = (a+b)/2 mod Q and out1 = (a−b)/2 mod Q. The halving can be disabled per transaction, which yields plain (a+b) mod Q and (a−b) mod Q. The block is a 2-stage, fully flow-controlled pipeline with valid/ready on both sides and a tag carried alongside the data. It sits between the INTT coefficient memory read port and the write-back path, so stalls from memory arbitration propagate without data loss.

## Interface
- DATA_WIDTH, ntt_pkg::DATA_WIDTH (12 for Kyber): coefficient width.
- Q, ntt_pkg::Q (3329): modulus, odd, Q < 2^DATA_WIDTH.
- TAG_WIDTH, 8: opaque sideband (address/index) passed through with each pair.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_data  in  DATA_WIDTH×2  in_data[0]=a, in_data[1]=b, each required in [0, Q).
- in_halve  in  1  1: divide results by 2 mod Q; 0: no halving.
- in_tag  in  TAG_WIDTH  sideband.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH×2  results, each in [0, Q).
- out_tag  out  TAG_WIDTH  tag of the pair on out_data.
- range_err  out  1  sticky flag: an accepted operand was ≥ Q.

## Operation
- Transfer on input when in_valid & in_ready; transfer on output when out_valid & out_ready.
- Stage 1 (registered on input transfer):
  - s = a+b, DATA_WIDTH+1 bits; s1 = s−Q if s ≥ Q, else s.
  - d = a−b, signed DATA_WIDTH+1 bits; d1 = d+Q if d < 0, else d.
  - halve, tag and a valid bit v1 are registered alongside.
- Stage 2 (registered): for each x in {s1, d1}: if halve & x[0], then y = (x+Q)>>1 (DATA_WIDTH+1-bit add); if halve & !x[0], then y = x>>1; if !halve, then y = x. Tag and valid bit v2 are registered alongside.
- Results are always in [0, Q). The result is unspecified but still in [0, 2^DATA_WIDTH) when the operand precondition is violated.
- Flow control (bubble-collapsing):
  - Stage 2 loads when !v2 | out_ready.
  - Stage 1 loads when !v1 | stage 2 loads.
  - in_ready = !v1 | !v2 | out_ready. The ready path is combinational from out_ready; there is no skid buffer.
- out_valid = v2, and out_data/out_tag = stage-2 registers. Outputs are held stable while out_valid & !out_ready.
- range_err is set on the cycle after any accepted pair with a ≥ Q or b ≥ Q. It is cleared only by reset.
- Reset (rst_n=0 at a clock edge): v1=v2=0, out_valid=0, range_err=0, out_data=0, out_tag=0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation discards both in-flight pairs; no partial output is produced.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 pair/cycle while out_ready=1.
- With out_ready held low, the block absorbs exactly 2 pairs, then in_ready=0.
- Simultaneous input and output transfer on a full pipe is legal: both stages shift and in_ready stays 1.
- When out_ready rises after a stall, the first held pair leaves on that edge and a new pair can be accepted in the same cycle.
- Order is strictly preserved.

## Structure
- ntt_pkg holds DATA_WIDTH, Q, and the `coef_t` typedef (logic [DATA_WIDTH-1:0]). Add a `recover_pair_t` struct to ntt_pkg containing data[2], halve and tag for the stage registers.
- Sub-module `mod_half`: combinational conditional-add-Q-and-shift, instantiated twice in stage 2. It is reusable by other INTT scaling logic.

## Test plan
- Basic, halve=1, a=5, b=3 -> out=(4, 1), 2 cycles after acceptance.
- Negative difference and odd halving, halve=1, a=3, b=5 -> out=(4, 3328).
- Wrap case, halve=1, a=3328, b=3328 -> out=(3328, 0). Case a=1, b=0 -> out=(1665, 1665).
- No halving, halve=0, a=3000, b=1000 -> out=(671, 2000). Case a=0, b=1 -> (1, 3328).
- Backpressure: stream 10 tagged pairs (tags 0..9) with out_ready toggling randomly and once held low for 5 cycles.
  - All 10 pairs emerge in order with correct values.
  - in_ready drops after exactly 2 pairs are buffered.
  - out_data is stable while stalled.
- Reset and error:
  - Feed a=3329, b=0 -> range_err=1 next cycle, and it stays high.
  - Assert rst_n=0 with 2 pairs in flight -> next cycle out_valid=0, range_err=0, in_ready=1, and no stale pair is emitted afterwards.
